input_request_ctrl: RTL and testbench

Sequencer between the MIPS core's IN instruction and the board switch/push-button input stage. When the core executes IN, the block stalls the core and raises the input-wait flag toward the switch stage. It waits for the debounced confirm, captures the 16-bit switch word, then releases the core for exactly one cycle with the word on the register-file write path. It also drives a blinking prompt LED while waiting and enforces the confirm-release handshake so one button press never satisfies two IN instructions.

---
 rtl/mips_io_pkg.sv | 13 +
 rtl/input_request_ctrl_prompt_blinker.sv | 47 ++++
 rtl/input_request_ctrl.sv | 99 +++++++++
 tb/tb_input_request_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_io_pkg.sv
// rtl/mips_io_pkg.sv - shared FSM encoding and switch width for the MIPS board I/O controllers
package mips_io_pkg;

  // Width of the board switch word delivered by the input stage.
  localparam int SW_W = 16;

  // Sequencer states, shared with the output controller.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/input_request_ctrl_prompt_blinker.sv
// rtl/input_request_ctrl_prompt_blinker.sv - prompt LED divider that blinks while enabled
module prompt_blinker #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic led_o
);

  localparam int              CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Hold the divider cleared and the phase at "on" while disabled, so each
  // enable period starts lit for a full half-period.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // The LED is forced dark whenever the blinker is not enabled.
  assign led_o = en_i & phase_q;

endmodule

// File: rtl/input_request_ctrl.sv
// rtl/input_request_ctrl.sv - IN-instruction sequencer between the core and the switch input stage
module input_request_ctrl
  import mips_io_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SIGN_EXT  = 0,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic [SW_W-1:0]   sw_data,
  input  logic              sw_confirm,
  output logic              flag_input,
  output logic              cpu_stall,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  output logic              prompt_led
);

  logic [1:0]        state_q, state_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              armed_q, armed_d;
  logic              capture;
  logic [DATA_W-1:0] sw_ext;

  // Widen the switch word to the core's register width.
  always_comb begin
    if (SIGN_EXT != 0) begin
      sw_ext = {{(DATA_W-SW_W){sw_data[SW_W-1]}}, sw_data};
    end else begin
      sw_ext = {{(DATA_W-SW_W){1'b0}}, sw_data};
    end
  end

  // Sequencer next state; an abort (in_req dropped) in WAIT wins over a
  // confirm because the core is no longer waiting for the word.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_req) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!in_req) begin
          state_d = ST_IDLE;
        end else if (sw_confirm && armed_q) begin
          state_d = ST_CAPTURE;
          capture = 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!sw_confirm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A confirm only counts after it has been seen low since the last capture
  // or reset, so a press held across a reset cannot satisfy a new IN.
  always_comb begin
    armed_d = sw_confirm ? (armed_q & ~capture) : 1'b1;
    data_d  = capture ? sw_ext : data_q;
    flag_d  = (state_d == ST_WAIT);
  end

  // State, flag, capture and arming registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
      data_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      data_q  <= data_d;
      armed_q <= armed_d;
    end
  end

  prompt_blinker #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blinker (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == ST_WAIT),
    .led_o (prompt_led)
  );

  assign flag_input = flag_q;
  assign cpu_stall  = in_req & (state_q != ST_CAPTURE);
  assign in_valid   = (state_q == ST_CAPTURE);
  assign in_data    = data_q;

endmodule

// File: tb/tb_input_request_ctrl.sv
// tb/tb_input_request_ctrl.sv - randomized self-checking bench for input_request_ctrl
module tb_input_request_ctrl;

  localparam int BDIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req;
  logic [15:0] sw_data;
  logic        sw_confirm;

  logic        flag_z, stall_z, valid_z, led_z;
  logic [31:0] data_z;
  logic        flag_s, stall_s, valid_s, led_s;
  logic [31:0] data_s;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_word = 16'h0;

  always #5 clk = ~clk;

  input_request_ctrl #(.DATA_W(32), .SIGN_EXT(0), .BLINK_DIV(BDIV)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .sw_data(sw_data), .sw_confirm(sw_confirm),
    .flag_input(flag_z), .cpu_stall(stall_z), .in_valid(valid_z), .in_data(data_z),
    .prompt_led(led_z)
  );

  input_request_ctrl #(.DATA_W(32), .SIGN_EXT(1), .BLINK_DIV(BDIV)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .sw_data(sw_data), .sw_confirm(sw_confirm),
    .flag_input(flag_s), .cpu_stall(stall_s), .in_valid(valid_s), .in_data(data_s),
    .prompt_led(led_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] zext(input logic [15:0] w);
    return {16'h0000, w};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] w);
    return {{16{w[15]}}, w};
  endfunction

  // LED level w cycles after entering the wait: lit for the first BDIV cycles.
  function automatic logic led_at(input int w);
    return ((w / BDIV) % 2) == 0;
  endfunction

  task automatic check_all(input logic e_flag, input logic e_stall, input logic e_valid,
                           input logic e_led);
    chk("flag_z",  flag_z,  e_flag);
    chk("flag_s",  flag_s,  e_flag);
    chk("stall_z", stall_z, e_stall);
    chk("stall_s", stall_s, e_stall);
    chk("valid_z", valid_z, e_valid);
    chk("valid_s", valid_s, e_valid);
    chk("led_z",   led_z,   e_led);
    chk("led_s",   led_s,   e_led);
    chk("data_z",  data_z,  zext(last_word));
    chk("data_s",  data_s,  sext(last_word));
  endtask

  // Drive one cycle of inputs just after the edge, check mid-cycle.
  task automatic cycle(input logic req, input logic conf, input logic [15:0] d,
                       input logic e_flag, input logic e_stall, input logic e_valid,
                       input logic e_led);
    in_req     = req;
    sw_confirm = conf;
    sw_data    = d;
    @(negedge clk);
    check_all(e_flag, e_stall, e_valid, e_led);
    @(posedge clk);
    #1;
  endtask

  // One IN: request at c=0, confirm high from c=d through c=d+h, captured
  // word visible at c=d+1, then h release cycles and g idle cycles.
  task automatic run_txn(input logic [15:0] word, input int d, input int h, input bit b2b,
                         input int g);
    logic [15:0] junk;
    junk = 16'($urandom);
    cycle(1'b1, 1'b0, junk, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= d; c++) begin
      junk = 16'($urandom);
      cycle(1'b1, c == d, (c == d) ? word : junk, 1'b1, 1'b1, 1'b0, led_at(c - 1));
    end
    last_word = word;
    junk = 16'($urandom);
    cycle(1'b1, 1'b1, junk, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < h; r++) begin
      junk = 16'($urandom);
      cycle(b2b, r < h - 1, junk, 1'b0, b2b, 1'b0, 1'b0);
    end
    if (!b2b) begin
      for (int i = 0; i < g; i++) begin
        junk = 16'($urandom);
        cycle(1'b0, 1'b0, junk, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  // IN abandoned after a wait cycles: no capture, data unchanged.
  task automatic run_abort(input int a);
    logic [15:0] junk;
    junk = 16'($urandom);
    cycle(1'b1, 1'b0, junk, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= a; c++) begin
      junk = 16'($urandom);
      cycle(1'b1, 1'b0, junk, 1'b1, 1'b1, 1'b0, led_at(c - 1));
    end
    junk = 16'($urandom);
    cycle(1'b0, 1'b0, junk, 1'b1, 1'b0, 1'b0, led_at(a));
    cycle(1'b0, 1'b0, junk, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_reset_mid_wait();
    logic [15:0] junk;
    junk = 16'($urandom);
    cycle(1'b1, 1'b0, junk, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, junk, 1'b1, 1'b1, 1'b0, led_at(0));
    cycle(1'b1, 1'b0, junk, 1'b1, 1'b1, 1'b0, led_at(1));
    #2;
    rst_n      = 1'b0;
    sw_confirm = 1'b1;
    in_req     = 1'b0;
    #1;
    last_word = 16'h0;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, junk, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, junk, 1'b1, 1'b1, 1'b0, led_at(k));
    end
    cycle(1'b1, 1'b0, junk, 1'b1, 1'b1, 1'b0, led_at(6));
    cycle(1'b1, 1'b1, 16'h5A3C, 1'b1, 1'b1, 1'b0, led_at(7));
    last_word = 16'h5A3C;
    cycle(1'b1, 1'b1, junk, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, junk, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, junk, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_req     = 1'b0;
    sw_confirm = 1'b0;
    sw_data    = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    in_req = 1'b1;
    #1;
    chk("rst_stall_z", stall_z, 1'b1);
    chk("rst_stall_s", stall_s, 1'b1);
    in_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_txn(16'hBEEF, 10, 3, 1'b0, 2);
    run_txn(16'h8001, 2, 1, 1'b0, 1);
    run_txn(16'h7FFF, 1, 2, 1'b0, 0);
    run_txn(16'h1234, 4, 3, 1'b1, 0);
    run_txn(16'h0042, 3, 3, 1'b0, 2);
    run_abort(3);
    run_txn(16'hA5A5, 20, 2, 1'b0, 1);
    run_reset_mid_wait();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run_abort($urandom_range(1, 6));
      end else begin
        run_txn(16'($urandom), $urandom_range(1, 12), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
